cache_ram_bytelane: RTL and testbench



---
 rtl/cache_ram_pkg.sv | 20 ++
 rtl/cache_ram_lane.sv | 36 +++
 rtl/cache_ram_bytelane.sv | 173 +++++++++++++++++
 tb/tb_cache_ram_bytelane.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cache_ram_pkg.sv
// Shared types and helpers for the byte-lane cache RAM.
package cache_ram_pkg;

   localparam int LANE_W = 8;

   typedef enum logic [1:0] {
      ST_RESET,
      ST_CLEAR,
      ST_READY
   } state_e;

   function automatic logic [LANE_W-1:0] lane_merge(
      input logic [LANE_W-1:0] old_byte,
      input logic [LANE_W-1:0] new_byte,
      input logic              we
   );
      return we ? new_byte : old_byte;
   endfunction

endpackage

// File: rtl/cache_ram_lane.sv
// One 8-bit true dual-port lane array with registered, read-first outputs.
module cache_ram_lane
   import cache_ram_pkg::*;
#(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              en_a,
   input  logic              we_a,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [LANE_W-1:0] din_a,
   output logic [LANE_W-1:0] dout_a,
   input  logic              en_b,
   input  logic              we_b,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [LANE_W-1:0] din_b,
   output logic [LANE_W-1:0] dout_b
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [LANE_W-1:0] mem [0:DEPTH-1];
   logic [LANE_W-1:0] rd_a_q;
   logic [LANE_W-1:0] rd_b_q;

   always_ff @(posedge clk) begin
      if (we_a) mem[addr_a] <= din_a;
      if (we_b) mem[addr_b] <= din_b;
      if (en_a) rd_a_q <= mem[addr_a];
      if (en_b) rd_b_q <= mem[addr_b];
   end

   assign dout_a = rd_a_q;
   assign dout_b = rd_b_q;

endmodule

// File: rtl/cache_ram_bytelane.sv
// Dual-port byte-lane cache RAM with clear sweep, write-first reads,
// cross-port forwarding and optional output register.
module cache_ram_bytelane
   import cache_ram_pkg::*;
#(
   parameter int         LANES          = 4,
   parameter int         ADDR_W         = 12,
   parameter int         OUT_REG        = 1,
   parameter int         CLEAR_ON_RESET = 1,
   parameter logic [7:0] CLEAR_VALUE    = 8'h00
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clr,
   output logic                    busy,
   input  logic                    ena,
   input  logic [LANES-1:0]        wea,
   input  logic [ADDR_W-1:0]       addra,
   input  logic [LANES*LANE_W-1:0] dina,
   output logic [LANES*LANE_W-1:0] douta,
   input  logic                    enb,
   input  logic [LANES-1:0]        web,
   input  logic [ADDR_W-1:0]       addrb,
   input  logic [LANES*LANE_W-1:0] dinb,
   output logic [LANES*LANE_W-1:0] doutb
);

   localparam int                W         = LANES * LANE_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              busy_q;
   logic              sweep_wr;
   logic              client_ok;

   always_comb begin
      sweep_wr  = 1'b0;
      client_ok = 1'b0;
      state_d   = state_q;
      cnt_d     = cnt_q;
      if (!reset) begin
         case (state_q)
            ST_RESET: sweep_wr = (CLEAR_ON_RESET != 0);
            ST_CLEAR: sweep_wr = 1'b1;
            ST_READY: begin
               sweep_wr  = clr;
               client_ok = !clr;
            end
            default: ;
         endcase
      end
      // The edge that writes the last address also returns to READY, so no wrap write.
      if (sweep_wr) begin
         if (cnt_q == LAST_ADDR) begin
            state_d = ST_READY;
            cnt_d   = '0;
         end else begin
            state_d = ST_CLEAR;
            cnt_d   = cnt_q + 1'b1;
         end
      end else if (state_q == ST_RESET) begin
         state_d = ST_READY;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_RESET;
         cnt_q   <= '0;
         busy_q  <= (CLEAR_ON_RESET != 0);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= (state_d != ST_READY);
      end
   end

   assign busy = busy_q;

   logic             same_addr;
   logic             rd_a_en, rd_b_en;
   logic [LANES-1:0] wa_eff, wb_eff;
   logic [LANES-1:0] ram_we_a;
   logic [ADDR_W-1:0] ram_addr_a;
   logic [W-1:0]     ram_din_a;

   assign same_addr = (addra == addrb);
   assign rd_a_en   = client_ok && ena;
   assign rd_b_en   = client_ok && enb;
   assign wa_eff    = rd_a_en ? wea : '0;
   // Port A wins a same-lane, same-address collision.
   assign wb_eff    = (rd_b_en ? web : '0) & ~(same_addr ? wa_eff : '0);

   assign ram_we_a   = sweep_wr ? '1 : wa_eff;
   assign ram_addr_a = sweep_wr ? cnt_q : addra;
   assign ram_din_a  = sweep_wr ? {LANES{CLEAR_VALUE}} : dina;

   logic [W-1:0]     ram_rd_a, ram_rd_b;
   logic [W-1:0]     fdata_a_d, fdata_b_d, fdata_a_q, fdata_b_q;
   logic [LANES-1:0] fmask_a_q, fmask_b_q;
   logic [W-1:0]     stage1_a, stage1_b;

   // Bytes written this cycle are captured beside the RAM read and merged
   // after it; a reset mask of all ones forces the outputs to zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         fmask_a_q <= '1;
         fmask_b_q <= '1;
         fdata_a_q <= '0;
         fdata_b_q <= '0;
      end else begin
         if (rd_a_en) begin
            fmask_a_q <= wa_eff | (same_addr ? wb_eff : '0);
            fdata_a_q <= fdata_a_d;
         end
         if (rd_b_en) begin
            fmask_b_q <= wb_eff | (same_addr ? wa_eff : '0);
            fdata_b_q <= fdata_b_d;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         cache_ram_lane #(.ADDR_W(ADDR_W)) u_lane (
            .clk    (clk),
            .en_a   (rd_a_en),
            .we_a   (ram_we_a[gi]),
            .addr_a (ram_addr_a),
            .din_a  (ram_din_a[gi*LANE_W +: LANE_W]),
            .dout_a (ram_rd_a[gi*LANE_W +: LANE_W]),
            .en_b   (rd_b_en),
            .we_b   (wb_eff[gi]),
            .addr_b (addrb),
            .din_b  (dinb[gi*LANE_W +: LANE_W]),
            .dout_b (ram_rd_b[gi*LANE_W +: LANE_W])
         );

         assign fdata_a_d[gi*LANE_W +: LANE_W] =
            lane_merge(dinb[gi*LANE_W +: LANE_W], dina[gi*LANE_W +: LANE_W], wa_eff[gi]);
         assign fdata_b_d[gi*LANE_W +: LANE_W] =
            lane_merge(dina[gi*LANE_W +: LANE_W], dinb[gi*LANE_W +: LANE_W], wb_eff[gi]);

         assign stage1_a[gi*LANE_W +: LANE_W] =
            lane_merge(ram_rd_a[gi*LANE_W +: LANE_W], fdata_a_q[gi*LANE_W +: LANE_W], fmask_a_q[gi]);
         assign stage1_b[gi*LANE_W +: LANE_W] =
            lane_merge(ram_rd_b[gi*LANE_W +: LANE_W], fdata_b_q[gi*LANE_W +: LANE_W], fmask_b_q[gi]);
      end

      if (OUT_REG != 0) begin : g_oreg
         logic [W-1:0] dout_a_q, dout_b_q;

         always_ff @(posedge clk) begin
            if (reset) begin
               dout_a_q <= '0;
               dout_b_q <= '0;
            end else begin
               dout_a_q <= stage1_a;
               dout_b_q <= stage1_b;
            end
         end

         assign douta = dout_a_q;
         assign doutb = dout_b_q;
      end else begin : g_noreg
         assign douta = stage1_a;
         assign doutb = stage1_b;
      end
   endgenerate

endmodule

// File: tb/tb_cache_ram_bytelane.sv
// Directed bench for cache_ram_bytelane: one registered-output and one
// unregistered-output instance driven by the same stimulus.
module tb_cache_ram_bytelane;

   logic        clk = 1'b0;
   logic        reset, clr;
   logic        ena, enb;
   logic [3:0]  wea, web;
   logic [3:0]  addra, addrb;
   logic [31:0] dina, dinb;
   logic        busy, busy0;
   logic [31:0] douta, doutb, douta0, doutb0;

   int checks = 0;
   int errors = 0;
   int n;

   always #5 clk = ~clk;

   cache_ram_bytelane #(
      .LANES(4), .ADDR_W(4), .OUT_REG(1), .CLEAR_ON_RESET(1), .CLEAR_VALUE(8'h00)
   ) dut (
      .clk(clk), .reset(reset), .clr(clr), .busy(busy),
      .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta),
      .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb)
   );

   cache_ram_bytelane #(
      .LANES(4), .ADDR_W(4), .OUT_REG(0), .CLEAR_ON_RESET(1), .CLEAR_VALUE(8'h00)
   ) dut0 (
      .clk(clk), .reset(reset), .clr(clr), .busy(busy0),
      .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta0),
      .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb0)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic idle();
      ena = 1'b0; wea = 4'h0; addra = 4'h0; dina = 32'h0;
      enb = 1'b0; web = 4'h0; addrb = 4'h0; dinb = 32'h0;
   endtask

   task automatic wr_a(input logic [3:0] a, input logic [31:0] d);
      ena = 1'b1; wea = 4'hF; addra = a; dina = d;
      tick();
      idle();
   endtask

   // Read through port A and check both latencies.
   task automatic rd_a(input logic [3:0] a, input logic [31:0] exp, input string tag);
      ena = 1'b1; wea = 4'h0; addra = a;
      tick();
      idle();
      chk({tag, "_lat1"}, douta0, exp);
      tick();
      chk({tag, "_lat2"}, douta, exp);
      $display("read A addr=%0d douta=%h douta0=%h", a, douta, douta0);
   endtask

   task automatic wait_ready(input string tag);
      n = 0;
      while (busy && n < 40) begin
         tick();
         n++;
      end
      chk(tag, n, 16);
      chk({tag, "_busy0"}, {31'b0, busy0}, 32'h0);
   endtask

   initial begin
      idle();
      reset = 1'b1;
      clr   = 1'b0;
      tick();
      tick();
      chk("rst_douta", douta, 32'h0);
      chk("rst_doutb", doutb, 32'h0);
      chk("rst_douta0", douta0, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'h1);

      // Power-up sweep: busy stays high for 16 cycles.
      reset = 1'b0;
      wait_ready("sweep_len");
      for (int i = 0; i < 16; i++) rd_a(i[3:0], 32'h0, $sformatf("swept%0d", i));

      // Same-port write-first merge.
      wr_a(4'd5, 32'hDEADBEEF);
      ena = 1'b1; wea = 4'b0101; addra = 4'd5; dina = 32'h11223344;
      tick();
      idle();
      chk("wfirst_lat1", douta0, 32'hDE22BE44);
      tick();
      chk("wfirst_lat2", douta, 32'hDE22BE44);
      $display("write-first merge douta=%h", douta);
      rd_a(4'd5, 32'hDE22BE44, "wfirst_stored");

      // A writes 9 while B reads 9.
      ena = 1'b1; wea = 4'hF; addra = 4'd9; dina = 32'hAAAAAAAA;
      enb = 1'b1; web = 4'h0; addrb = 4'd9;
      tick();
      idle();
      chk("fwd_ab_lat1", doutb0, 32'hAAAAAAAA);
      tick();
      chk("fwd_ab_lat2", doutb, 32'hAAAAAAAA);
      $display("forward A->B doutb=%h", doutb);

      // B writes 3 while A reads 3.
      ena = 1'b1; wea = 4'h0; addra = 4'd3;
      enb = 1'b1; web = 4'hF; addrb = 4'd3; dinb = 32'hCAFEF00D;
      tick();
      idle();
      tick();
      chk("fwd_ba", douta, 32'hCAFEF00D);
      $display("forward B->A douta=%h", douta);

      // Write-write collision on address 7; A wins lane 1.
      ena = 1'b1; wea = 4'b0011; addra = 4'd7; dina = 32'h00001111;
      enb = 1'b1; web = 4'b0110; addrb = 4'd7; dinb = 32'h00222200;
      tick();
      idle();
      tick();
      chk("coll_fwd_b", doutb, 32'h00221111);
      rd_a(4'd7, 32'h00221111, "coll_stored");

      // Back-to-back reads: latency 1 versus 2, then hold with ena=0.
      wr_a(4'd12, 32'h12345678);
      wr_a(4'd1, 32'h11111111);
      wr_a(4'd2, 32'h22222222);
      wr_a(4'd3, 32'h33333333);
      ena = 1'b1; wea = 4'h0; addra = 4'd1;
      tick();
      chk("b2b_r1_lat1", douta0, 32'h11111111);
      addra = 4'd2;
      tick();
      chk("b2b_r2_lat1", douta0, 32'h22222222);
      chk("b2b_r1_lat2", douta, 32'h11111111);
      addra = 4'd3;
      tick();
      chk("b2b_r3_lat1", douta0, 32'h33333333);
      chk("b2b_r2_lat2", douta, 32'h22222222);
      idle();
      tick();
      chk("b2b_hold_lat1", douta0, 32'h33333333);
      chk("b2b_r3_lat2", douta, 32'h33333333);
      tick();
      chk("b2b_hold_lat2", douta, 32'h33333333);
      $display("back-to-back done douta=%h douta0=%h", douta, douta0);

      // clr pulse, dropped read during busy, reset at sweep address 8.
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_busy", {31'b0, busy}, 32'h1);
      ena = 1'b1; wea = 4'h0; addra = 4'd12;
      for (int k = 1; k <= 7; k++) begin
         tick();
         chk($sformatf("clr_busy_%0d", k), {31'b0, busy}, 32'h1);
         chk($sformatf("clr_hold_%0d", k), douta, 32'h33333333);
         chk($sformatf("clr_hold0_%0d", k), douta0, 32'h33333333);
      end
      reset = 1'b1;
      idle();
      tick();
      chk("midrst_douta", douta, 32'h0);
      chk("midrst_busy", {31'b0, busy}, 32'h1);
      reset = 1'b0;
      wait_ready("resweep_len");
      rd_a(4'd12, 32'h0, "resweep12");
      rd_a(4'd9, 32'h0, "resweep9");
      rd_a(4'd15, 32'h0, "resweep15");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
